// File: rtl/gpr_wb.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wb
// Brief    : GPR writeback arbiter. It merges ALU results with a queue of load
//            results onto a single register-file write port, applies a
//            starvation guard to the load queue, and keeps a scoreboard of
//            pending loads.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_wb #(
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // ALU writeback source
  input  logic        alu_wb_val,
  input  logic [4:0]  alu_wb_adr,
  input  logic [31:0] alu_wb_dat,
  output logic        alu_wb_rdy,
  // load writeback source (queued)
  input  logic        ld_wb_val,
  input  logic [4:0]  ld_wb_adr,
  input  logic [31:0] ld_wb_dat,
  output logic        ld_wb_rdy,
  // register-file write port
  output logic        wr_en_0,
  output logic [4:0]  wr_adr_0,
  output logic [31:0] wr_dat_0,
  // load issue / scoreboard
  input  logic        iss_val,
  input  logic [4:0]  iss_adr,
  output logic [31:0] busy,
  output logic        sb_err
);

  // A depth of 1 still needs a 1-bit pointer so that the arrays index cleanly.
  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(LQ_DEPTH);
  localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_MAX);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [4:0]       q_adr_q [LQ_DEPTH];
  logic [31:0]      q_dat_q [LQ_DEPTH];
  logic [4:0]       q_adr_d [LQ_DEPTH];
  logic [31:0]      q_dat_d [LQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             alu_rdy_q, alu_rdy_d;
  logic             wr_en_q, wr_en_d;
  logic [4:0]       wr_adr_q, wr_adr_d;
  logic [31:0]      wr_dat_q, wr_dat_d;
  logic [31:0]      busy_q, busy_d;
  logic             sb_err_q, sb_err_d;

  // --------------------------------------------------------------------------
  // Arbitration signals
  // --------------------------------------------------------------------------
  logic        alu_sel;
  logic        q_empty;
  logic        q_has_room;
  logic        push;
  logic        pop;
  logic [4:0]  head_adr;
  logic [31:0] head_dat;

  // Source select: an accepted ALU result always wins, otherwise drain the queue.
  always_comb begin
    q_empty    = (cnt_q == '0);
    q_has_room = (cnt_q < DEPTH_C);
    alu_sel    = alu_wb_val & alu_rdy_q;
    push       = ld_wb_val & q_has_room;
    pop        = ~alu_sel & ~q_empty;
    head_adr   = q_adr_q[rd_ptr_q];
    head_dat   = q_dat_q[rd_ptr_q];
  end

  // Queue storage and pointers; the head is read from registered state only,
  // so a load pushed this cycle cannot be popped before the next one.
  always_comb begin
    q_adr_d  = q_adr_q;
    q_dat_d  = q_dat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      q_adr_d[wr_ptr_q] = ld_wb_adr;
      q_dat_d[wr_ptr_q] = ld_wb_dat;
      wr_ptr_d          = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Starvation guard: count ALU wins against a waiting queue, then block the
  // ALU for one cycle so the queue head is forced out.
  always_comb begin
    starve_d = starve_q;
    if (pop || q_empty) begin
      starve_d = '0;
    end else if (alu_sel && (starve_q != STARVE_C)) begin
      starve_d = starve_q + STV_ONE;
    end
    alu_rdy_d = (starve_d != STARVE_C);
  end

  // Write-port register: the address and data hold their last values when idle.
  always_comb begin
    wr_en_d  = 1'b0;
    wr_adr_d = wr_adr_q;
    wr_dat_d = wr_dat_q;
    if (alu_sel) begin
      wr_en_d  = 1'b1;
      wr_adr_d = alu_wb_adr;
      wr_dat_d = alu_wb_dat;
    end else if (pop) begin
      wr_en_d  = 1'b1;
      wr_adr_d = head_adr;
      wr_dat_d = head_dat;
    end
  end

  // Scoreboard: a load write clears its GPR, and an issue (applied last) sets it.
  // Hazards latch into the sticky error flag without blocking the write.
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[head_adr] = 1'b0;
    end
    if (iss_val) begin
      busy_d[iss_adr] = 1'b1;
    end
    sb_err_d = sb_err_q
             | (iss_val & busy_q[iss_adr])
             | (alu_sel & busy_q[alu_wb_adr]);
  end

  // Register all state; reset empties the queue and drops in-flight writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        q_adr_q[i] <= '0;
        q_dat_q[i] <= '0;
      end
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
      alu_rdy_q <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_adr_q  <= '0;
      wr_dat_q  <= '0;
      busy_q    <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      q_adr_q   <= q_adr_d;
      q_dat_q   <= q_dat_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      alu_rdy_q <= alu_rdy_d;
      wr_en_q   <= wr_en_d;
      wr_adr_q  <= wr_adr_d;
      wr_dat_q  <= wr_dat_d;
      busy_q    <= busy_d;
      sb_err_q  <= sb_err_d;
    end
  end

  // Output drive.
  assign alu_wb_rdy = alu_rdy_q;
  assign ld_wb_rdy  = q_has_room;
  assign wr_en_0    = wr_en_q;
  assign wr_adr_0   = wr_adr_q;
  assign wr_dat_0   = wr_dat_q;
  assign busy       = busy_q;
  assign sb_err     = sb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_wb
// Brief    : Directed self-checking bench for gpr_wb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_wb;

  logic        clk;
  logic        rst_n;
  logic        alu_wb_val;
  logic [4:0]  alu_wb_adr;
  logic [31:0] alu_wb_dat;
  logic        alu_wb_rdy;
  logic        ld_wb_val;
  logic [4:0]  ld_wb_adr;
  logic [31:0] ld_wb_dat;
  logic        ld_wb_rdy;
  logic        wr_en_0;
  logic [4:0]  wr_adr_0;
  logic [31:0] wr_dat_0;
  logic        iss_val;
  logic [4:0]  iss_adr;
  logic [31:0] busy;
  logic        sb_err;

  int n_checks;
  int n_fail;

  gpr_wb #(
    .LQ_DEPTH   (4),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_wb_val (alu_wb_val),
    .alu_wb_adr (alu_wb_adr),
    .alu_wb_dat (alu_wb_dat),
    .alu_wb_rdy (alu_wb_rdy),
    .ld_wb_val  (ld_wb_val),
    .ld_wb_adr  (ld_wb_adr),
    .ld_wb_dat  (ld_wb_dat),
    .ld_wb_rdy  (ld_wb_rdy),
    .wr_en_0    (wr_en_0),
    .wr_adr_0   (wr_adr_0),
    .wr_dat_0   (wr_dat_0),
    .iss_val    (iss_val),
    .iss_adr    (iss_adr),
    .busy       (busy),
    .sb_err     (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_wb_val = 1'b0;
    alu_wb_adr = '0;
    alu_wb_dat = '0;
    ld_wb_val  = 1'b0;
    ld_wb_adr  = '0;
    ld_wb_dat  = '0;
    iss_val    = 1'b0;
    iss_adr    = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"},   32'(wr_en_0),    32'd0);
    chk({tag, "_wr_adr"},  32'(wr_adr_0),   32'd0);
    chk({tag, "_wr_dat"},  wr_dat_0,        32'd0);
    chk({tag, "_busy"},    busy,            32'd0);
    chk({tag, "_sb_err"},  32'(sb_err),     32'd0);
    chk({tag, "_alu_rdy"}, 32'(alu_wb_rdy), 32'd1);
    chk({tag, "_ld_rdy"},  32'(ld_wb_rdy),  32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst_n = 1'b0;
    step();
    step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();
    chk("idle_wr_en", 32'(wr_en_0), 32'd0);

    // ---------------- ALU only: one cycle latency, single write ----------------
    alu_wb_val = 1'b1; alu_wb_adr = 5'd5; alu_wb_dat = 32'hDEADBEEF;
    step();
    idle();
    chk("alu_wr_en",  32'(wr_en_0),  32'd1);
    chk("alu_wr_adr", 32'(wr_adr_0), 32'd5);
    chk("alu_wr_dat", wr_dat_0,      32'hDEADBEEF);
    step();
    chk("alu_after_en",  32'(wr_en_0),  32'd0);
    chk("alu_hold_adr",  32'(wr_adr_0), 32'd5);
    chk("alu_hold_dat",  wr_dat_0,      32'hDEADBEEF);

    // ---------------- Scoreboard set and clear ----------------
    iss_val = 1'b1; iss_adr = 5'd7;
    step();
    idle();
    chk("sb_busy7_set", busy, 32'h0000_0080);
    ld_wb_val = 1'b1; ld_wb_adr = 5'd7; ld_wb_dat = 32'h0000_0077;
    step();
    idle();
    chk("sb_no_bypass_en", 32'(wr_en_0), 32'd0);
    chk("sb_busy7_held",   busy,         32'h0000_0080);
    step();
    chk("sb_ld_wr_en",   32'(wr_en_0),  32'd1);
    chk("sb_ld_wr_adr",  32'(wr_adr_0), 32'd7);
    chk("sb_ld_wr_dat",  wr_dat_0,      32'h0000_0077);
    chk("sb_busy7_clr",  busy,          32'd0);
    chk("sb_err_clean",  32'(sb_err),   32'd0);
    step();
    chk("sb_after_en", 32'(wr_en_0), 32'd0);

    // ---------------- Queue full, starvation guard, ordering ----------------
    alu_wb_val = 1'b1; alu_wb_adr = 5'd20; alu_wb_dat = 32'h0000_A0A0;
    for (int k = 1; k <= 4; k++) begin
      ld_wb_val = 1'b1; ld_wb_adr = 5'(k); ld_wb_dat = 32'h100 + 32'(k);
      step();
      chk("qf_alu_wr_adr", 32'(wr_adr_0), 32'd20);
    end
    ld_wb_val = 1'b0;
    chk("qf_ld_rdy_full", 32'(ld_wb_rdy),  32'd0);
    chk("qf_alu_rdy_hi",  32'(alu_wb_rdy), 32'd1);
    step();
    chk("qf_alu_win4", 32'(wr_adr_0), 32'd20);
    for (int k = 1; k <= 4; k++) begin
      chk("qf_alu_rdy_lo", 32'(alu_wb_rdy), 32'd0);
      step();
      chk("qf_pop_en",     32'(wr_en_0),    32'd1);
      chk("qf_pop_adr",    32'(wr_adr_0),   32'(k));
      chk("qf_pop_dat",    wr_dat_0,        32'h100 + 32'(k));
      chk("qf_alu_rdy_re", 32'(alu_wb_rdy), 32'd1);
      chk("qf_ld_rdy",     32'(ld_wb_rdy),  32'd1);
      if (k < 4) begin
        for (int j = 0; j < 4; j++) begin
          step();
          chk("qf_alu_between", 32'(wr_adr_0), 32'd20);
        end
      end
    end
    step();
    chk("qf_drained_alu_rdy", 32'(alu_wb_rdy), 32'd1);
    idle();
    step();
    step();
    chk("qf_idle_en", 32'(wr_en_0), 32'd0);

    // ---------------- Hazards: double issue, ALU write to busy ----------------
    iss_val = 1'b1; iss_adr = 5'd9;
    step();
    chk("hz_first_iss_err", 32'(sb_err), 32'd0);
    step();
    idle();
    chk("hz_double_iss_err", 32'(sb_err), 32'd1);
    alu_wb_val = 1'b1; alu_wb_adr = 5'd9; alu_wb_dat = 32'h0000_0099;
    step();
    idle();
    chk("hz_alu_wr_en",  32'(wr_en_0),  32'd1);
    chk("hz_alu_wr_adr", 32'(wr_adr_0), 32'd9);
    chk("hz_alu_wr_dat", wr_dat_0,      32'h0000_0099);
    chk("hz_err_sticky", 32'(sb_err),   32'd1);
    chk("hz_busy9_kept", busy,          32'h0000_0200);

    // ---------------- Set/clear collision on GPR 3 ----------------
    ld_wb_val = 1'b1; ld_wb_adr = 5'd3; ld_wb_dat = 32'h0000_0033;
    step();
    idle();
    iss_val = 1'b1; iss_adr = 5'd3;
    step();
    idle();
    chk("col_wr_adr", 32'(wr_adr_0), 32'd3);
    chk("col_busy",   busy,          32'h0000_0208);

    // ---------------- Reset mid-operation ----------------
    alu_wb_val = 1'b1; alu_wb_adr = 5'd21; alu_wb_dat = 32'h0000_2121;
    for (int k = 0; k < 3; k++) begin
      ld_wb_val = 1'b1; ld_wb_adr = 5'(10 + k); ld_wb_dat = 32'h0000_0A00 + 32'(k);
      step();
    end
    idle();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_rst_no_wr", 32'(wr_en_0), 32'd0);
    end

    // ---------------- Load to non-busy GPR, then ALU-only hazard ----------------
    ld_wb_val = 1'b1; ld_wb_adr = 5'd2; ld_wb_dat = 32'h0000_0022;
    step();
    idle();
    step();
    chk("nb_wr_adr", 32'(wr_adr_0), 32'd2);
    chk("nb_wr_dat", wr_dat_0,      32'h0000_0022);
    chk("nb_busy",   busy,          32'd0);
    chk("nb_err",    32'(sb_err),   32'd0);
    iss_val = 1'b1; iss_adr = 5'd12;
    step();
    idle();
    chk("alu_hz_pre_err", 32'(sb_err), 32'd0);
    alu_wb_val = 1'b1; alu_wb_adr = 5'd12; alu_wb_dat = 32'h0000_000C;
    step();
    idle();
    chk("alu_hz_err",    32'(sb_err),   32'd1);
    chk("alu_hz_wr_adr", 32'(wr_adr_0), 32'd12);
    chk("alu_hz_busy",   busy,          32'h0000_1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpr_wb.md
GPR_WB -- requirements
Module: gpr_wb

Interface
REQ-001 SHALL have parameter LQ_DEPTH, default 4, load-writeback queue entries (power of 2, 2..8).
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive cycles a non-empty queue may lose arbitration to ALU.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports alu_wb_val/alu_wb_adr/alu_wb_dat  input  1/5/32  ALU result writeback.
REQ-006 SHALL have port alu_wb_rdy  output  1  ALU writeback accepted when val&rdy.
REQ-007 SHALL have ports ld_wb_val/ld_wb_adr/ld_wb_dat  input  1/5/32  load result writeback.
REQ-008 SHALL have port ld_wb_rdy  output  1  queue can accept; transfer on val&rdy.
REQ-009 SHALL have ports wr_en_0/wr_adr_0/wr_dat_0  output  1/5/32  register-file write port, registered.
REQ-010 SHALL have ports iss_val/iss_adr  input  1/5  load issue, marks target GPR pending.
REQ-011 SHALL have port busy  output  32  per-GPR pending-load scoreboard.
REQ-012 SHALL have port sb_err  output  1  sticky scoreboard hazard flag.

Function
REQ-013 SHALL hold load writebacks in an LQ_DEPTH FIFO; ld_wb_rdy = (count < LQ_DEPTH) from registered count, no same-cycle pop credit.
REQ-014 SHALL, each cycle, select one source: accepted ALU writeback if alu_wb_val&alu_wb_rdy, else FIFO head if non-empty, else none.
REQ-015 SHALL register the selected source onto wr_en_0/wr_adr_0/wr_dat_0 at the next edge; ALU latency 1 cycle (cycle N in -> cycle N+1 on write port).
REQ-016 SHALL make a load accepted in cycle N eligible for pop no earlier than cycle N+1, i.e. earliest on write port in N+2; no queue bypass.
REQ-017 SHALL drive wr_en_0=0 in cycles following a no-select cycle; wr_adr_0/wr_dat_0 hold last values.
REQ-018 SHALL count consecutive cycles where the queue is non-empty and the ALU wins; reset counter on any pop or empty queue.
REQ-019 SHALL deassert alu_wb_rdy (registered) for exactly the cycle after the counter reaches STARVE_MAX, forcing a pop; counter clears on that pop.
REQ-020 SHALL require the ALU source to hold val/adr/dat stable while alu_wb_rdy=0.
REQ-021 SHALL preserve FIFO order; simultaneous push and pop with count=LQ_DEPTH impossible (rdy low); with count between, both occur and count unchanged.
REQ-022 SHALL set busy[iss_adr] at the edge when iss_val=1.
REQ-023 SHALL clear busy[r] at the edge when a load-sourced write to r is registered onto the write port.
REQ-024 SHALL let set win over clear for the same GPR in the same cycle.
REQ-025 SHALL set sb_err when iss_val targets a GPR already busy, or an ALU write is selected for a busy GPR; write still proceeds; busy unchanged by ALU writes.
REQ-026 SHALL treat GPR 0 as ordinary; no address is special.
REQ-027 SHALL accept load writebacks to non-busy GPRs without error or busy change.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force: FIFO empty, count 0, starve counter 0, busy=0, sb_err=0, wr_en_0=0, wr_adr_0=0, wr_dat_0=0, alu_wb_rdy=1, ld_wb_rdy=1.
REQ-029 SHALL discard queued and in-flight writebacks on reset mid-operation; first write after release only from inputs sampled after release.

Verification
REQ-030 SHALL test ALU only: alu val, adr=5, dat=0xDEADBEEF in cycle N -> wr_en_0=1, adr 5, dat 0xDEADBEEF in N+1, nothing else.
REQ-031 SHALL test queue full: 4 loads (adr 1..4) with ALU active every cycle -> ld_wb_rdy=0 after 4th push; after STARVE_MAX ALU wins, alu_wb_rdy=0 one cycle, adr 1 written; order 1,2,3,4 preserved over runs.
REQ-032 SHALL test scoreboard: iss adr 7 -> busy[7]=1; load wb adr 7 -> busy[7]=0 the cycle wr_en_0 shows adr 7; sb_err=0.
REQ-033 SHALL test hazards: iss adr 9 twice -> sb_err=1 sticky; and ALU write adr 9 while busy -> write occurs, sb_err stays 1.
REQ-034 SHALL test set/clear collision: iss adr 3 in same cycle load wb to 3 reaches write port -> busy[3]=1 afterward.
REQ-035 SHALL test reset mid-operation: 3 queued loads, rst_n low one cycle -> all outputs at REQ-028 values, no queued write appears after release.
